// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter
module uart_tx_fifo #(
    parameter int BIT_DIV = 868,
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       uart_tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0] TIMER_LAST = 16'(BIT_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;
    logic [15:0]          timer;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 push;
    logic                 pop;
    logic                 bit_end;

    assign tx_full  = (count == DEPTH_CNT);
    assign tx_empty = (count == '0);
    assign tx_busy  = (state != IDLE);
    assign bit_end  = (timer == TIMER_LAST);
    assign push     = tx_wr && !tx_full;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                // Reload straight from the stop bit so consecutive frames abut.
                if (bit_end) begin
                    if (!tx_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The line register follows the state one cycle later, giving write->start latency of two edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shreg[0];
                default: uart_tx <= 1'b1;
            endcase
            if (pop) begin
                shreg   <= mem[rd_ptr];
                timer   <= '0;
                bit_idx <= '0;
            end else if (state == IDLE) begin
                timer <= '0;
            end else begin
                timer <= bit_end ? 16'd0 : timer + 16'd1;
                if (state == DATA && bit_end) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

endmodule
